// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stall, MULT/DIV busy window with HI/LO
// interlock, taken-branch flush. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic        ID_EX_MDStart,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        IF_ID_HiLoOp,
  input  logic        EX_BranchTaken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCycles,
`endif
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Busy,
  output logic        MD_Done
);

  typedef enum logic [0:0] {S_RUN, S_MD_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, hilo_stall, done_hit;
  logic             flush_act, stall_act;

  always_comb begin
    load_use   = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                 ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                  (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
    hilo_stall = (state_q == S_MD_BUSY) && IF_ID_HiLoOp;
    flush_act  = Rst_n && EX_BranchTaken;
    stall_act  = Rst_n && !EX_BranchTaken && (load_use || hilo_stall);
  end

  // Counter holds the busy cycles remaining including the current one, so the
  // window after the issue cycle is exactly MD_LATENCY cycles long.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_hit = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ID_EX_MDStart) begin
          state_d = S_MD_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY);
        end else begin
          cnt_d = '0;
        end
      end
      S_MD_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          done_hit = (cnt_q == CNT_W'(1));
          state_d  = S_RUN;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    MD_Busy      = 1'b0;
    MD_Done      = 1'b0;
    if (!Rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else begin
      MD_Busy = (state_q == S_MD_BUSY);
      MD_Done = done_hit;
      if (EX_BranchTaken) begin
        // ID instruction is squashed, so any stall it would cause is moot
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (load_use || hilo_stall) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_act && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = flush_act ^ stall_act;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (MD_LATENCY 4 and 12) share one stimulus set.
module tb_hazard_stall_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       ID_EX_MemRead, ID_EX_MDStart, IF_ID_UsesRt, IF_ID_HiLoOp, EX_BranchTaken;
  logic [4:0] ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;

  logic a_pcw, a_ifw, a_fl, a_bub, a_busy, a_done;
  logic b_pcw, b_ifw, b_fl, b_bub, b_busy, b_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(8)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_MDStart(ID_EX_MDStart),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_HiLoOp(IF_ID_HiLoOp), .EX_BranchTaken(EX_BranchTaken),
`ifdef HAZARD_PERF_CNT_EN
    .StallCycles(a_stall), .FlushCycles(a_flush),
`endif
    .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl), .ID_EX_Bubble(a_bub),
    .MD_Busy(a_busy), .MD_Done(a_done)
  );

  hazard_stall_ctrl #(.MD_LATENCY(12), .CNT_W(8)) dut12 (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_MDStart(ID_EX_MDStart),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_HiLoOp(IF_ID_HiLoOp), .EX_BranchTaken(EX_BranchTaken),
`ifdef HAZARD_PERF_CNT_EN
    .StallCycles(b_stall), .FlushCycles(b_flush),
`endif
    .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl), .ID_EX_Bubble(b_bub),
    .MD_Busy(b_busy), .MD_Done(b_done)
  );

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy, MD_Done}
  wire [5:0] a_out = {a_pcw, a_ifw, a_fl, a_bub, a_busy, a_done};
  wire [5:0] b_out = {b_pcw, b_ifw, b_fl, b_bub, b_busy, b_done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; ID_EX_MDStart = 0;
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0; IF_ID_UsesRt = 0;
    IF_ID_HiLoOp = 0; EX_BranchTaken = 0;
  endtask

  // Advance one edge, then let combinational outputs settle on the new inputs.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    clr();
    Rst_n = 0;
    tick();
    chk("reset_out", 32'(a_out), 32'b001100);
    Rst_n = 1; #1;
    chk("idle", 32'(a_out), 32'b110000);

    // load-use on Rs: one stall cycle, then the bubble removes the load
    ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd8; IF_ID_RegisterRs = 5'd8; #1;
    chk("lu_rs_stall", 32'(a_out), 32'b000100);
    tick();
    ID_EX_MemRead = 0; #1;
    chk("lu_rs_after", 32'(a_out), 32'b110000);

    clr(); ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd9; IF_ID_RegisterRt = 5'd9; IF_ID_UsesRt = 1; #1;
    chk("lu_rt_used", 32'(a_out), 32'b000100);
    IF_ID_UsesRt = 0; #1;
    chk("lu_rt_unused", 32'(a_out), 32'b110000);

    clr(); ID_EX_MemRead = 1; #1;
    chk("lu_zero_reg", 32'(a_out), 32'b110000);

    clr(); ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd8; IF_ID_RegisterRs = 5'd8; EX_BranchTaken = 1; #1;
    chk("branch_wins", 32'(a_out), 32'b111100);
    clr(); tick();

    // MULT with latency 4, MFLO in ID from the next cycle
    ID_EX_MDStart = 1; #1;
    chk("md_issue", 32'(a_out), 32'b110000);
    tick();
    ID_EX_MDStart = 0; IF_ID_HiLoOp = 1; #1;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("md_stall_c%0d", c), 32'(a_out), 32'b000110);
      tick();
    end
    chk("md_done_c4", 32'(a_out), 32'b000111);
    tick();
    chk("md_release_c5", 32'(a_out), 32'b110000);
    clr(); tick();
    for (int c = 0; c < 12; c++) tick();   // let dut12 drain

    // branch inside busy window, stray MDStart ignored, combined stalls
    ID_EX_MDStart = 1; tick();
    ID_EX_MDStart = 0; IF_ID_HiLoOp = 1; EX_BranchTaken = 1; #1;
    chk("busy_branch", 32'(a_out), 32'b111110);
    tick();
    EX_BranchTaken = 0; ID_EX_MDStart = 1; #1;
    chk("busy_stray_start", 32'(a_out), 32'b000110);
    tick();
    ID_EX_MDStart = 0; ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd3; IF_ID_RegisterRs = 5'd3; #1;
    chk("busy_lu_combined", 32'(a_out), 32'b000110);
    tick();
    clr(); IF_ID_HiLoOp = 1; #1;
    chk("busy_done_no_reload", 32'(a_out), 32'b000111);
    tick();
    chk("busy_release", 32'(a_out), 32'b110000);
    clr(); tick();
    for (int c = 0; c < 12; c++) tick();

    // reset at counter 10 (latency 12) abandons the operation
    ID_EX_MDStart = 1; tick();
    ID_EX_MDStart = 0; tick(); tick();
    chk("md12_busy_cnt10", 32'(b_out), 32'b110010);
    Rst_n = 0; IF_ID_HiLoOp = 1; #1;
    chk("md12_in_reset", 32'(b_out), 32'b001100);
    tick();
    Rst_n = 1; #1;
    chk("md12_after_reset", 32'(b_out), 32'b110000);
    clr();
    for (int c = 0; c < 14; c++) begin
      tick();
      chk($sformatf("md12_no_done_%0d", c), 32'({b_busy, b_done}), 32'b00);
    end

`ifdef HAZARD_PERF_CNT_EN
    Rst_n = 0; tick(); Rst_n = 1; #1;
    chk("perf_stall_rst", a_stall, 32'd0);
    chk("perf_flush_rst", a_flush, 32'd0);
    for (int k = 0; k < 3; k++) begin
      ID_EX_MemRead = 1; ID_EX_RegisterRt = 5'd8; IF_ID_RegisterRs = 5'd8; tick();
      clr(); tick();
    end
    for (int k = 0; k < 2; k++) begin
      EX_BranchTaken = 1; tick();
      clr(); tick();
    end
    chk("perf_stall", a_stall, 32'd3);
    chk("perf_flush", a_flush, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
